// File: rtl/psum_acc_col.sv
// Column partial-sum accumulator: adds/overwrites a bank of entries from a systolic column, then drains them.
// Latency: a write lands one edge after in_valid; first drained word is valid on the edge after the drain command.
// Backpressure: drained word and out_valid hold until out_ready; in_s has no stall path (caller paces with in_valid).
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   in_s, in_valid        one psum per valid cycle, written to the entry at the pointer
//   start_acc, clear      begin accumulation pass; clear=1 overwrites, clear=0 adds
//   drain, relu_en        begin readout of every entry, optional ReLU on the way out
//   simd                  1 = two packed signed lanes, 0 = one signed word (sampled with a command)
//   out_data, out_valid,
//   out_ready             readout stream with valid/ready handshake
//   busy, done            busy while not idle; done pulses one cycle after a pass or drain ends
module psum_acc_col #(
  parameter int psum_bw = 18,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] in_s,
  input  logic               in_valid,
  input  logic               start_acc,
  input  logic               clear,
  input  logic               drain,
  input  logic               simd,
  input  logic               relu_en,
  output logic [psum_bw-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int addr_bw = (depth > 1) ? $clog2(depth) : 1;
  localparam int lo_w    = psum_bw / 2;
  localparam int hi_w    = psum_bw - lo_w;
  localparam logic [addr_bw-1:0] last_ptr = addr_bw'(depth - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [addr_bw-1:0] ptr_q, ptr_d, ptr_inc;
  logic               clear_q, clear_d;
  logic               simd_q, simd_d;
  logic               relu_q, relu_d;
  logic               out_valid_q, out_valid_d;
  logic [psum_bw-1:0] out_data_q, out_data_d;
  logic               done_q, done_d;
  logic               wr_en;
  logic [psum_bw-1:0] wr_data;
  logic [psum_bw-1:0] entry_q [depth];

  // Signed saturating add. In SIMD mode the two lanes are summed separately
  // so an overflow in one lane can never carry into or clamp the other.
  function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b,
                                                 input logic           simd_mode);
    logic [psum_bw:0]   s_full;
    logic [lo_w:0]      s_lo;
    logic [hi_w:0]      s_hi;
    logic [psum_bw-1:0] r;
    s_full = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    s_lo   = {a[lo_w-1], a[lo_w-1:0]} + {b[lo_w-1], b[lo_w-1:0]};
    s_hi   = {a[psum_bw-1], a[psum_bw-1:lo_w]} + {b[psum_bw-1], b[psum_bw-1:lo_w]};
    if (simd_mode) begin
      // Overflow shows up as the two top bits of the widened sum disagreeing.
      if (s_hi[hi_w] != s_hi[hi_w-1])
        r[psum_bw-1:lo_w] = s_hi[hi_w] ? {1'b1, {(hi_w-1){1'b0}}} : {1'b0, {(hi_w-1){1'b1}}};
      else
        r[psum_bw-1:lo_w] = s_hi[hi_w-1:0];
      if (s_lo[lo_w] != s_lo[lo_w-1])
        r[lo_w-1:0] = s_lo[lo_w] ? {1'b1, {(lo_w-1){1'b0}}} : {1'b0, {(lo_w-1){1'b1}}};
      else
        r[lo_w-1:0] = s_lo[lo_w-1:0];
    end else begin
      if (s_full[psum_bw] != s_full[psum_bw-1])
        r = s_full[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      else
        r = s_full[psum_bw-1:0];
    end
    return r;
  endfunction

  // Readout transform: ReLU zeroes each negative lane (or the whole negative word).
  function automatic logic [psum_bw-1:0] relu_fn(input logic [psum_bw-1:0] v,
                                                 input logic           simd_mode,
                                                 input logic           relu_mode);
    logic [psum_bw-1:0] r;
    r = v;
    if (relu_mode) begin
      if (simd_mode) begin
        if (v[psum_bw-1]) r[psum_bw-1:lo_w] = '0;
        if (v[lo_w-1])    r[lo_w-1:0]       = '0;
      end else if (v[psum_bw-1]) begin
        r = '0;
      end
    end
    return r;
  endfunction

  assign ptr_inc = ptr_q + addr_bw'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    clear_d     = clear_q;
    simd_d      = simd_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    unique case (state_q)
      IDLE: begin
        // start_acc has priority; a simultaneous drain is simply dropped.
        if (start_acc) begin
          state_d = ACC;
          ptr_d   = '0;
          clear_d = clear;
          simd_d  = simd;
        end else if (drain) begin
          state_d     = DRAIN;
          ptr_d       = '0;
          simd_d      = simd;
          relu_d      = relu_en;
          out_valid_d = 1'b1;
          out_data_d  = relu_fn(entry_q[0], simd, relu_en);
        end
      end
      ACC: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_data = clear_q ? in_s : sat_add(entry_q[ptr_q], in_s, simd_q);
          if (ptr_q == last_ptr) begin
            state_d = IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_inc;
          end
        end
      end
      DRAIN: begin
        // out_valid is always high here, so out_ready alone marks a transfer.
        if (out_ready) begin
          if (ptr_q == last_ptr) begin
            state_d     = IDLE;
            ptr_d       = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            ptr_d      = ptr_inc;
            out_data_d = relu_fn(entry_q[ptr_inc], simd_q, relu_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      clear_q     <= 1'b0;
      simd_q      <= 1'b0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < depth; i++) entry_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      clear_q     <= clear_d;
      simd_q      <= simd_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      if (wr_en) entry_q[ptr_q] <= wr_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: doc/psum_acc_col.md
PSUM_ACC_COL -- requirements
Module: psum_acc_col

Interface
REQ-001: Parameter psum_bw, default 18, SHALL set the width of the partial sum taken from the bottom mac_tile out_s of one array column.
REQ-002: Parameter depth, default 16, SHALL set the number of accumulator entries (output rows) per pass; addr_bw = log2(depth).
REQ-003: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  SHALL be synchronous and active-high.
REQ-005: in_s  input  psum_bw  SHALL carry the partial sum from the column's bottom mac_tile out_s.
REQ-006: in_valid  input  1  SHALL qualify in_s as one valid psum for the current entry.
REQ-007: start_acc  input  1  SHALL be a one-cycle command that begins an accumulation pass.
REQ-008: clear  input  1  SHALL be sampled with start_acc; 1 = overwrite entries, 0 = add to entries.
REQ-009: drain  input  1  SHALL be a one-cycle command that begins readout of all entries.
REQ-010: simd  input  1  SHALL be sampled with start_acc or drain; 1 = two packed signed 9-bit lanes [17:9],[8:0], 0 = one signed 18-bit value.
REQ-011: relu_en  input  1  SHALL be sampled with drain; enables ReLU on readout.
REQ-012: out_data  output  psum_bw  SHALL carry the readout entry.
REQ-013: out_valid  output  1  SHALL qualify out_data.
REQ-014: out_ready  input  1  SHALL be the consumer's accept signal.
REQ-015: busy  output  1  SHALL be 1 whenever state is not IDLE.
REQ-016: done  output  1  SHALL pulse high for one cycle when a pass or drain completes.

Function
REQ-017: FSM states SHALL be IDLE, ACC and DRAIN; an entry pointer ptr (addr_bw bits) SHALL index the buffer.
REQ-018: In IDLE, start_acc SHALL move to ACC with ptr=0; drain SHALL move to DRAIN with ptr=0; if both are high, start_acc SHALL win and drain SHALL be dropped.
REQ-019: start_acc, drain and their sampled mode bits SHALL be ignored outside IDLE; in_valid SHALL be ignored outside ACC.
REQ-020: In ACC, each edge with in_valid=1 SHALL write entry[ptr] = in_s (clear=1) or entry[ptr] + in_s (clear=0), then increment ptr; cycles with in_valid=0 SHALL hold all state.
REQ-021: The write with ptr=depth-1 SHALL end the pass: state returns to IDLE, ptr wraps to 0, and done=1 in the following cycle.
REQ-022: Non-SIMD add SHALL be signed 18-bit, saturating to [-131072, 131071].
REQ-023: SIMD add SHALL use two independent signed 9-bit lanes, each saturating to [-256, 255], with no carry between lanes.
REQ-024: On the edge entering DRAIN, out_valid SHALL go to 1 with out_data = f(entry[0]), where f is ReLU per lane (or per full word) when relu_en=1, otherwise identity.
REQ-025: A transfer SHALL occur on each edge with out_valid=1 and out_ready=1; at that edge out_data SHALL advance to f(entry[ptr+1]).
REQ-026: While out_ready=0, out_data and out_valid SHALL hold stable.
REQ-027: The transfer of entry depth-1 SHALL clear out_valid, return to IDLE, and assert done for the next cycle; each entry SHALL be emitted exactly once per drain.
REQ-028: A drain SHALL NOT modify buffer contents, so repeated drains SHALL return identical data.

Reset
REQ-029: While reset=1 at an edge, state SHALL become IDLE, ptr=0, all buffer entries 0, out_data=0, out_valid=0, busy=0, done=0.
REQ-030: Reset SHALL override any command on the same edge; reset during ACC or DRAIN SHALL discard partial results with no done pulse.

Verification
REQ-031: Reset check: after reset, all outputs are 0 and busy=0; a drain then returns 16 zeros and done=1 once.
REQ-032: Non-SIMD accumulate: clear pass with in_s=k for k=1..16, with random in_valid gaps, then add pass with the same values, then drain with out_ready=1 -> outputs 2,4,...,32 in order; done pulses after each pass and after the drain.
REQ-033: Saturation/ReLU: entry0 131071+1 -> 131071; entry1 -131072+(-1) -> -131072; drain with relu_en=1 -> entry1 reads 0.
REQ-034: SIMD: {4,2}+{4,2} -> {8,4}; {200,-5}+{100,-1} -> {255,-6}; with relu_en=1 the second reads {255,0}, lower lane unaffected by upper saturation.
REQ-035: Backpressure: out_ready alternating 1/0 and a 5-cycle stall -> each entry exactly once, out_data stable while stalled, same order as REQ-032.
REQ-036: Reset mid-DRAIN after 5 transfers -> out_valid=0 the next cycle, no done pulse; a following drain returns 16 zeros.
